// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses the synchronous RAM, latches the IR,
// resolves branches locally and freezes on HALT until reset.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  start_pc,
    input  logic [15:0] ram_rddata,
    input  logic        ir_ack,
    input  logic        use_data_addr,
    input  logic [7:0]  data_addr,
    input  logic        Z_in,
    input  logic        N_in,
    input  logic        V_in,
    output logic [7:0]  ram_addr,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        halted
);
    // state  | meaning
    // RESET  | load start_pc on the first edge after release
    // FETCH  | present pc to the RAM
    // LATCH  | RAM data valid; capture IR, bump pc, pick next state from opcode
    // ISSUE  | ir_valid to controller, wait for ir_ack
    // BRANCH | resolve condition on current flags, maybe load target
    // HALT   | frozen until reset
    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_LATCH, S_ISSUE, S_BRANCH, S_HALT
    } state_t;

    state_t     state;
    logic       branch_taken;
    logic [7:0] branch_target;

    always_comb begin
        branch_taken = 1'b0;
        unique case (ir[10:8])
            3'b000:  branch_taken = 1'b1;
            3'b001:  branch_taken = Z_in;
            3'b010:  branch_taken = ~Z_in;
            3'b011:  branch_taken = N_in ^ V_in;
            3'b100:  branch_taken = (N_in ^ V_in) | Z_in;
            default: branch_taken = 1'b0;
        endcase
    end

    // Sign extension of an 8-bit offset onto an 8-bit PC is the identity modulo 256.
    assign branch_target = pc + ir[7:0];

    always_comb begin
        ram_addr = pc;
        unique case (state)
            S_RESET: ram_addr = 8'd0;
            S_ISSUE: ram_addr = use_data_addr ? data_addr : pc;
            default: ram_addr = pc;
        endcase
    end

    assign ir_valid = (state == S_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RESET;
            pc     <= 8'd0;
            ir     <= 16'd0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    pc    <= start_pc;
                    state <= S_FETCH;
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    ir <= ram_rddata;
                    pc <= pc + 8'd1;
                    unique case (ram_rddata[15:13])
                        3'b001: state <= S_BRANCH;
                        3'b111: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: state <= S_ISSUE;
                    endcase
                end
                S_ISSUE: begin
                    if (ir_ack) state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (branch_taken) pc <= branch_target;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with an instruction-level reference model
// and a behavioural synchronous RAM.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  start_pc = 8'd0;
    logic [15:0] ram_rddata = 16'd0;
    logic        ir_ack = 1'b0;
    logic        use_data_addr = 1'b0;
    logic [7:0]  data_addr = 8'd0;
    logic        Z_in = 1'b0, N_in = 1'b0, V_in = 1'b0;
    logic [7:0]  ram_addr, pc;
    logic [15:0] ir;
    logic        ir_valid, halted;

    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    int total = 0;
    int bad = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .ram_rddata(ram_rddata),
        .ir_ack(ir_ack), .use_data_addr(use_data_addr), .data_addr(data_addr),
        .Z_in(Z_in), .N_in(N_in), .V_in(V_in),
        .ram_addr(ram_addr), .pc(pc), .ir(ir), .ir_valid(ir_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rddata <= mem[ram_addr];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_taken(input logic [2:0] c, input bit z, input bit n, input bit v);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] add_mod256(input logic [7:0] base, input logic [7:0] off);
        int s;
        s = int'(base) + int'($signed(off));
        s = ((s % 256) + 256) % 256;
        return 8'(s);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"}, 16'(pc), 16'd0);
        chk({tag, "_ir"}, ir, 16'd0);
        chk({tag, "_valid"}, 16'(ir_valid), 16'd0);
        chk({tag, "_halted"}, 16'(halted), 16'd0);
        chk({tag, "_addr"}, 16'(ram_addr), 16'd0);
    endtask

    // Called at the negedge while the DUT is in FETCH; returns at the next FETCH negedge
    // (or in HALT, or with reset asserted when abort is set).
    task automatic run_instr(input int stall, input bit use_da, input logic [7:0] da,
                             input bit z, input bit n, input bit v, input bit abort);
        logic [15:0] w;
        w = mem[m_pc];
        Z_in = z; N_in = n; V_in = v;
        chk("fetch_addr", 16'(ram_addr), 16'(m_pc));
        chk("fetch_valid", 16'(ir_valid), 16'd0);
        tick();
        chk("latch_valid", 16'(ir_valid), 16'd0);
        tick();
        m_pc = m_pc + 8'd1;
        chk("ir", ir, w);
        chk("pc", 16'(pc), 16'(m_pc));
        if (w[15:13] == 3'b001) begin
            chk("branch_valid", 16'(ir_valid), 16'd0);
            chk("branch_addr", 16'(ram_addr), 16'(m_pc));
            if (cond_taken(w[10:8], z, n, v)) m_pc = add_mod256(m_pc, w[7:0]);
            tick();
        end else if (w[15:13] == 3'b111) begin
            chk("halt_flag", 16'(halted), 16'd1);
            for (int i = 0; i < 10; i++) begin
                ir_ack = 1'($urandom_range(0, 1));
                tick();
                chk("halt_flag", 16'(halted), 16'd1);
                chk("halt_valid", 16'(ir_valid), 16'd0);
                chk("halt_pc", 16'(pc), 16'(m_pc));
                chk("halt_ir", ir, w);
                chk("halt_addr", 16'(ram_addr), 16'(m_pc));
            end
            ir_ack = 1'b0;
        end else begin
            chk("issue_valid", 16'(ir_valid), 16'd1);
            chk("issue_halted", 16'(halted), 16'd0);
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("stall_valid", 16'(ir_valid), 16'd1);
                chk("stall_ir", ir, w);
                chk("stall_pc", 16'(pc), 16'(m_pc));
                chk("stall_addr", 16'(ram_addr), 16'(m_pc));
            end
            if (abort) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("abort");
            end else begin
                use_data_addr = use_da;
                data_addr = da;
                ir_ack = 1'b1;
                #1 chk("ack_addr", 16'(ram_addr), use_da ? 16'(da) : 16'(m_pc));
                chk("ack_pc", 16'(pc), 16'(m_pc));
                tick();
                ir_ack = 1'b0;
                use_data_addr = 1'b0;
                data_addr = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:13] = 3'b001;
            if (w[15:13] == 3'b111) w[15:13] = 3'b000;
            mem[i] = w;
        end
        mem[16]  = 16'h4005;              // MOV R0,#5
        mem[17]  = 16'h2009;              // B +9
        mem[27]  = 16'h2105;              // BEQ +5
        mem[28]  = 16'h2310;              // BLT +16
        mem[45]  = 16'h20D2;              // B -46 -> 0
        mem[0]   = 16'h20FE;              // B -2 -> 0xFF
        mem[255] = 16'h2032;              // B +50 -> 50

        #12;
        chk_zero("reset");
        tick();
        start_pc = 8'd16;
        rst_n = 1'b1;
        tick();
        m_pc = 8'd16;
        run_instr(5, 1'b1, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b_plus9", 16'(m_pc), 16'd27);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("beq_fall", 16'(pc), 16'd28);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("blt_taken", 16'(pc), 16'd45);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_ff", 16'(pc), 16'h00FF);
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++)
            run_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);

        mem[m_pc] = 16'hE000;
        run_instr(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        #3 rst_n = 1'b0;
        #1 chk_zero("halt_reset");
        tick();
        start_pc = 8'd100;
        mem[100] = 16'h4321;
        rst_n = 1'b1;
        tick();
        m_pc = 8'd100;
        run_instr(2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        start_pc = 8'd200;
        mem[200] = 16'h5A5A;
        rst_n = 1'b1;
        tick();
        m_pc = 8'd200;
        for (int k = 0; k < 20; k++)
            run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
